// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with an 8-word block refill controller.
// Hits return in the same cycle; misses stall fetch while the block streams in from memory.
module icache_fill_ctrl #(
   parameter int unsigned INDEX_BITS      = 5,
   parameter int unsigned WORDS_PER_BLOCK = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_en,
   input  logic [15:0] req_addr,
   output logic [15:0] instr,
   output logic        stall,
   output logic        mem_rd_en,
   output logic [15:0] mem_addr,
   input  logic        mem_grant,
   input  logic [15:0] mem_data,
   input  logic        mem_data_valid
);

   localparam int unsigned SETS     = 1 << INDEX_BITS;
   localparam int unsigned OFF_BITS = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned TAG_BITS = 16 - INDEX_BITS - OFF_BITS - 1;
   localparam int unsigned CNT_BITS = OFF_BITS + 1;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [TAG_BITS-1:0]   fill_tag_q, fill_tag_d;
   logic [INDEX_BITS-1:0] fill_index_q, fill_index_d;
   logic [CNT_BITS-1:0]   issue_cnt_q, issue_cnt_d;
   logic [OFF_BITS-1:0]   recv_cnt_q, recv_cnt_d;
   logic [SETS-1:0]       valid_q, valid_d;

   logic [TAG_BITS-1:0]   tag_q  [SETS];
   logic [15:0]           data_q [SETS][WORDS_PER_BLOCK];

   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_index;
   logic [OFF_BITS-1:0]   req_off;
   logic                  hit_c;
   logic                  data_we_c;
   logic                  tag_we_c;
   logic                  unused_addr_lsb;

   assign req_tag         = req_addr[15 -: TAG_BITS];
   assign req_index       = req_addr[OFF_BITS+1 +: INDEX_BITS];
   assign req_off         = req_addr[1 +: OFF_BITS];
   assign unused_addr_lsb = req_addr[0];

   assign hit_c = req_en && (state_q == IDLE) && valid_q[req_index]
                  && (tag_q[req_index] == req_tag);

   // State, counters and valid bits; reset can land mid-fill and discards it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         fill_tag_q   <= '0;
         fill_index_q <= '0;
         issue_cnt_q  <= '0;
         recv_cnt_q   <= '0;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         fill_tag_q   <= fill_tag_d;
         fill_index_q <= fill_index_d;
         issue_cnt_q  <= issue_cnt_d;
         recv_cnt_q   <= recv_cnt_d;
         valid_q      <= valid_d;
      end
   end

   // Tag and data arrays are only trusted behind valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (data_we_c) begin
         data_q[fill_index_q][recv_cnt_q] <= mem_data;
      end
      if (tag_we_c) begin
         tag_q[fill_index_q] <= fill_tag_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      fill_tag_d   = fill_tag_q;
      fill_index_d = fill_index_q;
      issue_cnt_d  = issue_cnt_q;
      recv_cnt_d   = recv_cnt_q;
      valid_d      = valid_q;
      data_we_c    = 1'b0;
      tag_we_c     = 1'b0;
      instr        = 16'h0000;
      stall        = 1'b0;
      mem_rd_en    = 1'b0;
      mem_addr     = 16'h0000;

      case (state_q)
         IDLE: begin
            if (hit_c) begin
               instr = data_q[req_index][req_off];
            end else if (req_en) begin
               // Invalidate on entry so a partially refilled block never hits.
               stall              = 1'b1;
               state_d            = FILL;
               fill_tag_d         = req_tag;
               fill_index_d       = req_index;
               issue_cnt_d        = '0;
               recv_cnt_d         = '0;
               valid_d[req_index] = 1'b0;
            end
         end
         FILL: begin
            stall     = 1'b1;
            mem_rd_en = (issue_cnt_q < CNT_BITS'(WORDS_PER_BLOCK));
            mem_addr  = {fill_tag_q, fill_index_q, issue_cnt_q[OFF_BITS-1:0], 1'b0};
            if (mem_rd_en && mem_grant) begin
               issue_cnt_d = issue_cnt_q + CNT_BITS'(1);
            end
            if (mem_data_valid) begin
               data_we_c  = 1'b1;
               recv_cnt_d = recv_cnt_q + OFF_BITS'(1);
               if (recv_cnt_q == OFF_BITS'(WORDS_PER_BLOCK - 1)) begin
                  tag_we_c              = 1'b1;
                  valid_d[fill_index_q] = 1'b1;
                  state_d               = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl: a 4-cycle pipelined memory model feeds
// refills while queued expected read addresses and instructions are checked.
module tb_icache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_en;
   logic [15:0] req_addr;
   logic [15:0] instr;
   logic        stall;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic        mem_grant;
   logic [15:0] mem_data;
   logic        mem_data_valid;

   icache_fill_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .req_en         (req_en),
      .req_addr       (req_addr),
      .instr          (instr),
      .stall          (stall),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_grant      (mem_grant),
      .mem_data       (mem_data),
      .mem_data_valid (mem_data_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] addr;
   } pend_t;

   pend_t       pend_q[$];
   logic [15:0] exp_addr_q[$];
   logic [15:0] exp_instr_q[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rel = 0;
   int          gap_lo = 1000;
   int          gap_hi = -1;
   logic [15:0] gap_addr = 16'h0000;
   int          first_issue;
   int          last_issue;
   int          nstall;
   logic        stray = 1'b0;
   logic        obs_stall, obs_rd;
   logic [15:0] obs_addr, obs_instr;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_block(input logic [15:0] base);
      for (int w = 0; w < 8; w++) exp_addr_q.push_back(base + 16'(2 * w));
   endtask

   // One clock cycle: memory model drives, outputs are sampled mid-cycle, scoreboard pops.
   task automatic tick();
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         mem_data_valid = 1'b1;
         mem_data       = mem_word(pend_q[0].addr);
         void'(pend_q.pop_front());
      end else if (!stray) begin
         mem_data_valid = 1'b0;
         mem_data       = 16'h0000;
      end
      mem_grant = !(rel >= gap_lo && rel <= gap_hi);
      #2;
      obs_stall = stall;
      obs_rd    = mem_rd_en;
      obs_addr  = mem_addr;
      obs_instr = instr;
      if (rel >= gap_lo && rel <= gap_hi) chk("gap_addr_held", mem_addr, gap_addr);
      if (mem_rd_en && mem_grant) begin
         pend_q.push_back('{cyc + 4, mem_addr});
         if (first_issue < 0) first_issue = rel;
         last_issue = rel;
         checks++;
         assert (exp_addr_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_req: observed addr %0h expected no request", mem_addr);
         end
         if (exp_addr_q.size() != 0) chk("mem_addr", mem_addr, exp_addr_q.pop_front());
      end
      if (req_en && !stall) begin
         checks++;
         assert (exp_instr_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_instr: observed %0h expected none", instr);
         end
         if (exp_instr_q.size() != 0) chk("instr", instr, exp_instr_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      rel++;
   endtask

   // Present a fetch and run until it is served; returns the number of stalled cycles.
   task automatic run_req(input logic [15:0] a, input int exp_stalls,
                          input int redir_rel, input logic [15:0] redir_a);
      logic done;
      req_en   = 1'b1;
      req_addr = a;
      exp_instr_q.push_back(mem_word({a[15:1], 1'b0}));
      rel         = 0;
      nstall      = 0;
      first_issue = -1;
      last_issue  = -1;
      done        = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (rel == redir_rel) begin
            req_addr = redir_a;
            exp_instr_q.delete();
            exp_instr_q.push_back(mem_word({redir_a[15:1], 1'b0}));
         end
         tick();
         if (obs_stall) nstall++;
         else done = 1'b1;
      end
      chk("served_in_time", 32'(done), 32'd1);
      chk("stall_cycles", 32'(nstall), 32'(exp_stalls));
      req_en = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      req_en         = 1'b0;
      req_addr       = 16'h0000;
      mem_grant      = 1'b1;
      mem_data       = 16'h0000;
      mem_data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", stall, 1'b0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_rd_en", mem_rd_en, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      rst = 1'b0;
      tick();

      // Cold miss: requests in cycles 1-8, stall for 13 cycles
      push_block(16'h0000);
      run_req(16'h0000, 13, -1, 16'h0);
      chk("cold_first_issue", 32'(first_issue), 32'd1);
      chk("cold_last_issue", 32'(last_issue), 32'd8);

      // Spatial hits
      run_req(16'h0002, 0, -1, 16'h0);
      chk("hit1_rd_en", obs_rd, 1'b0);
      run_req(16'h000E, 0, -1, 16'h0);
      chk("hit7_rd_en", obs_rd, 1'b0);

      // Conflict eviction and re-miss
      push_block(16'h0200);
      run_req(16'h0200, 13, -1, 16'h0);
      run_req(16'h020E, 0, -1, 16'h0);
      push_block(16'h0000);
      run_req(16'h0000, 13, -1, 16'h0);

      // Grant gap in cycles 2-4 delays the fill by 3 cycles
      gap_lo   = 2;
      gap_hi   = 4;
      gap_addr = 16'h0402;
      push_block(16'h0400);
      run_req(16'h0400, 16, -1, 16'h0);
      chk("gap_last_issue", 32'(last_issue), 32'd11);
      gap_lo = 1000;
      gap_hi = -1;
      run_req(16'h0406, 0, -1, 16'h0);

      // Redirect mid-fill: first block completes, then the new PC fills
      push_block(16'h0010);
      push_block(16'h0100);
      run_req(16'h0010, 26, 3, 16'h0104);
      run_req(16'h0010, 0, -1, 16'h0);
      run_req(16'h0104, 0, -1, 16'h0);

      // Reset in cycle 6 of a fill
      push_block(16'h0020);
      req_en   = 1'b1;
      req_addr = 16'h0020;
      exp_instr_q.delete();
      rel = 0;
      repeat (6) tick();
      rst    = 1'b1;
      req_en = 1'b0;
      exp_addr_q.delete();
      #1;
      chk("midrst_rd_en", mem_rd_en, 1'b0);
      chk("midrst_stall", stall, 1'b0);
      chk("midrst_instr", instr, 16'h0000);
      chk("midrst_addr", mem_addr, 16'h0000);
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("idle_stall", obs_stall, 1'b0);
         chk("idle_rd_en", obs_rd, 1'b0);
         chk("idle_addr", obs_addr, 16'h0000);
      end
      stray          = 1'b1;
      mem_data_valid = 1'b1;
      mem_data       = 16'hDEAD;
      tick();
      chk("stray_stall", obs_stall, 1'b0);
      chk("stray_rd_en", obs_rd, 1'b0);
      stray = 1'b0;
      tick();
      push_block(16'h0020);
      run_req(16'h0020, 13, -1, 16'h0);
      run_req(16'h002E, 0, -1, 16'h0);
      push_block(16'h0000);
      run_req(16'h0000, 13, -1, 16'h0);

      chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
